// File: rtl/integrator_back_mc.sv
// Multi-channel backward-Euler integrator (y[n] = y[n-1] + x[n]) on MCLK_I.
// CLK_I is treated as data; one shared adder walks the channels one per cycle.
module integrator_back_mc #(
    parameter int DATA_BIT_WIDTH = 16,
    parameter int CHANNELS       = 2,
    parameter bit SATURATE       = 1'b1
) (
    input  logic                               MCLK_I,
    input  logic                               NRST_I,
    input  logic                               CLK_I,
    input  logic [CHANNELS*DATA_BIT_WIDTH-1:0] DATA_I,
    output logic                               CLK_O,
    output logic [CHANNELS*DATA_BIT_WIDTH-1:0] DATA_O,
    output logic [CHANNELS-1:0]                OFDET_O,
    output logic [CHANNELS-1:0]                UFDET_O,
    output logic                               BUSY_O,
    output logic                               MISS_O
);
    localparam int W    = DATA_BIT_WIDTH;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DLY  = CHANNELS + 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    localparam logic signed [W:0] MAX_V = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] MIN_V = {2'b11, {(W-1){1'b0}}};

    logic                  clk_s1, clk_s2, clk_s3;
    logic                  armed;
    logic [DLY-1:0]        clk_dly;
    logic [1:0]            state;
    logic [CH_W-1:0]       ch;
    logic signed [W-1:0]   x_p0 [CHANNELS];
    logic signed [W-1:0]   acc  [CHANNELS];
    logic [CHANNELS-1:0]   of_flag, uf_flag;
    logic                  rise, busy, last_ch, capture;
    logic signed [W:0]     sum;
    logic                  ovf, unf;

    function automatic logic signed [W-1:0] limit(input logic signed [W:0] s);
        if (SATURATE && (s > MAX_V)) begin
            return MAX_V[W-1:0];
        end else if (SATURATE && (s < MIN_V)) begin
            return MIN_V[W-1:0];
        end
        return s[W-1:0];
    endfunction

    assign rise    = clk_s2 & ~clk_s3 & armed;
    assign busy    = (state != ST_IDLE);
    assign last_ch = (ch == CH_W'(CHANNELS - 1));
    assign capture = (state == ST_IDLE) & rise & NRST_I;
    assign sum     = {acc[ch][W-1], acc[ch]} + {x_p0[ch][W-1], x_p0[ch]};
    assign ovf     = (sum > MAX_V);
    assign unf     = (sum < MIN_V);
    assign BUSY_O  = busy;
    assign CLK_O   = clk_dly[DLY-1];

    // Synchroniser and CLK_O delay line; armed only after CLK_I has really been low,
    // so a sample clock already high at reset release produces neither a sample nor CLK_O.
    always_ff @(posedge MCLK_I) begin
        if (!NRST_I) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            clk_s3  <= 1'b0;
            armed   <= 1'b0;
            clk_dly <= '0;
        end else begin
            clk_s1  <= CLK_I;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            if (!CLK_I) begin
                armed <= 1'b1;
            end
            clk_dly <= {clk_dly[DLY-2:0], clk_s2 & armed};
        end
    end

    // Stage p0: input capture on an accepted sample
    always_ff @(posedge MCLK_I) begin
        if (capture) begin
            for (int k = 0; k < CHANNELS; k++) begin
                x_p0[k] <= DATA_I[k*W +: W];
            end
        end
    end

    // Stage p1: one channel per cycle through the shared adder, then publish
    always_ff @(posedge MCLK_I) begin
        if (!NRST_I) begin
            state   <= ST_IDLE;
            ch      <= '0;
            MISS_O  <= 1'b0;
            DATA_O  <= '0;
            OFDET_O <= '0;
            UFDET_O <= '0;
            of_flag <= '0;
            uf_flag <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                acc[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        ch    <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc[ch]     <= limit(sum);
                    of_flag[ch] <= ovf;
                    uf_flag[ch] <= unf;
                    ch          <= ch + CH_W'(1);
                    if (last_ch) begin
                        state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        DATA_O[k*W +: W] <= acc[k];
                    end
                    OFDET_O <= of_flag;
                    UFDET_O <= uf_flag;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (rise && busy) begin
                MISS_O <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_integrator_back_mc.sv
// Bench for integrator_back_mc: wrap, saturate and single-channel instances at W=5,
// checked against an arithmetic model of the per-sample integrator.
module tb_integrator_back_mc;
    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic       nrst, clk_i;
    logic [9:0] din_w, din_s;
    logic [4:0] din_1;

    logic       clko_w, clko_s, clko_1;
    logic [9:0] dout_w, dout_s;
    logic [4:0] dout_1;
    logic [1:0] of_w, uf_w, of_s, uf_s;
    logic [0:0] of_1, uf_1;
    logic       busy_w, busy_s, busy_1, miss_w, miss_s, miss_1;

    integrator_back_mc #(.DATA_BIT_WIDTH(5), .CHANNELS(2), .SATURATE(1'b0)) dut_w (
        .MCLK_I(mclk), .NRST_I(nrst), .CLK_I(clk_i), .DATA_I(din_w), .CLK_O(clko_w),
        .DATA_O(dout_w), .OFDET_O(of_w), .UFDET_O(uf_w), .BUSY_O(busy_w), .MISS_O(miss_w));
    integrator_back_mc #(.DATA_BIT_WIDTH(5), .CHANNELS(2), .SATURATE(1'b1)) dut_s (
        .MCLK_I(mclk), .NRST_I(nrst), .CLK_I(clk_i), .DATA_I(din_s), .CLK_O(clko_s),
        .DATA_O(dout_s), .OFDET_O(of_s), .UFDET_O(uf_s), .BUSY_O(busy_s), .MISS_O(miss_s));
    integrator_back_mc #(.DATA_BIT_WIDTH(5), .CHANNELS(1), .SATURATE(1'b0)) dut_1 (
        .MCLK_I(mclk), .NRST_I(nrst), .CLK_I(clk_i), .DATA_I(din_1), .CLK_O(clko_1),
        .DATA_O(dout_1), .OFDET_O(of_1), .UFDET_O(uf_1), .BUSY_O(busy_1), .MISS_O(miss_1));

    int checks = 0;
    int failures = 0;

    int         acc_w [2];
    int         acc_s [2];
    int         acc_1;
    logic [1:0] eof_w, euf_w, eof_s, euf_s;
    logic       eof_1, euf_1;
    logic       exp_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [4:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [4:0] lo5(input int v);
        logic [31:0] t;
        t = v;
        return t[4:0];
    endfunction

    function automatic logic [9:0] pack2(input int a0, input int a1);
        return {lo5(a1), lo5(a0)};
    endfunction

    // Next accumulator value: clamp to [-16,15] or wrap modulo 32
    function automatic int mnext(input int a, input int x, input bit sat);
        int s;
        s = a + x;
        if (sat && s > 15) return 15;
        if (sat && s < -16) return -16;
        return ((s + 16) % 32 + 32) % 32 - 16;
    endfunction

    task automatic model_clear();
        acc_w[0] = 0; acc_w[1] = 0; acc_s[0] = 0; acc_s[1] = 0; acc_1 = 0;
        eof_w = '0; euf_w = '0; eof_s = '0; euf_s = '0; eof_1 = 1'b0; euf_1 = 1'b0;
        exp_miss = 1'b0;
    endtask

    task automatic model_step(input logic [9:0] dw, input logic [9:0] ds, input logic [4:0] d1);
        int x;
        for (int k = 0; k < 2; k++) begin
            x = sx(dw[k*5 +: 5]);
            eof_w[k] = (acc_w[k] + x > 15);
            euf_w[k] = (acc_w[k] + x < -16);
            acc_w[k] = mnext(acc_w[k], x, 1'b0);
            x = sx(ds[k*5 +: 5]);
            eof_s[k] = (acc_s[k] + x > 15);
            euf_s[k] = (acc_s[k] + x < -16);
            acc_s[k] = mnext(acc_s[k], x, 1'b1);
        end
        x = sx(d1);
        eof_1 = (acc_1 + x > 15);
        euf_1 = (acc_1 + x < -16);
        acc_1 = mnext(acc_1, x, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dout_w"}, dout_w, 0);
        chk({tag, "_dout_s"}, dout_s, 0);
        chk({tag, "_dout_1"}, dout_1, 0);
        chk({tag, "_flags"}, {of_w, uf_w, of_s, uf_s, of_1, uf_1}, 0);
        chk({tag, "_busy"}, {busy_w, busy_s, busy_1}, 0);
        chk({tag, "_miss"}, {miss_w, miss_s, miss_1}, 0);
        chk({tag, "_clko"}, {clko_w, clko_s, clko_1}, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge mclk);
        nrst = 1'b0;
        repeat (n) @(posedge mclk);
        #1;
        check_zero("reset");
        model_clear();
        @(negedge mclk);
        nrst = 1'b1;
    endtask

    // One well-formed sample: CLK_I high 10 cycles, low 8; k counts edges from T.
    task automatic run_sample(input logic [9:0] dw, input logic [9:0] ds, input logic [4:0] d1);
        logic [9:0] old_w, old_s;
        logic [4:0] old_1;
        old_w = pack2(acc_w[0], acc_w[1]);
        old_s = pack2(acc_s[0], acc_s[1]);
        old_1 = lo5(acc_1);
        @(negedge mclk);
        din_w = dw; din_s = ds; din_1 = d1;
        clk_i = 1'b1;
        model_step(dw, ds, d1);
        for (int k = 0; k < 10; k++) begin
            @(posedge mclk);
            #1;
            if (k == 0) chk("miss", {miss_w, miss_s, miss_1}, {3{exp_miss}});
            if (k == 1) chk("busy_before_rise", {busy_w, busy_s, busy_1}, 0);
            if (k == 2) chk("busy_at_rise", {busy_w, busy_s, busy_1}, 3'b111);
            if (k == 3) chk("hold_1", dout_1, old_1);
            if (k == 4) begin
                chk("hold_w", dout_w, old_w);
                chk("hold_s", dout_s, old_s);
                chk("busy_last_ch", {busy_w, busy_s}, 2'b11);
                chk("dout_1", dout_1, lo5(acc_1));
                chk("flags_1", {of_1, uf_1}, {eof_1, euf_1});
                chk("busy_fall_1", busy_1, 0);
                chk("clko_early_1", clko_1, 0);
            end
            if (k == 5) begin
                chk("dout_w", dout_w, pack2(acc_w[0], acc_w[1]));
                chk("dout_s", dout_s, pack2(acc_s[0], acc_s[1]));
                chk("flags_w", {of_w, uf_w}, {eof_w, euf_w});
                chk("flags_s", {of_s, uf_s}, {eof_s, euf_s});
                chk("busy_fall", {busy_w, busy_s}, 0);
                chk("clko_early", {clko_w, clko_s}, 0);
                chk("clko_rise_1", clko_1, 1);
            end
            if (k == 6) chk("clko_rise", {clko_w, clko_s}, 2'b11);
        end
        @(negedge mclk);
        clk_i = 1'b0;
        repeat (8) @(posedge mclk);
    endtask

    initial begin
        logic [9:0] rw, rs;
        logic [4:0] r1;
        nrst = 1'b0; clk_i = 1'b0; din_w = '0; din_s = '0; din_1 = '0;
        model_clear();
        do_reset(4);
        repeat (4) @(posedge mclk);

        // ch0 = +1, ch1 = -1 on both dual-channel units; single channel alternates -16/+15
        for (int i = 0; i < 20; i++) begin
            run_sample(10'b11111_00001, 10'b11111_00001, (i % 2 == 0) ? 5'b10000 : 5'b01111);
        end
        for (int i = 0; i < 4; i++) begin
            run_sample(10'b11111_11111, 10'b11111_11111, 5'b00001);
        end

        for (int i = 0; i < 24; i++) begin
            rw = 10'($urandom_range(0, 1023));
            rs = 10'($urandom_range(0, 1023));
            r1 = 5'($urandom_range(0, 31));
            run_sample(rw, rs, r1);
        end

        // Second CLK_I rise lands while busy: one sample accepted, miss latched
        rw = 10'($urandom_range(0, 1023));
        rs = 10'($urandom_range(0, 1023));
        r1 = 5'($urandom_range(0, 31));
        @(negedge mclk);
        din_w = rw; din_s = rs; din_1 = r1;
        clk_i = 1'b1;
        model_step(rw, rs, r1);
        exp_miss = 1'b1;
        @(posedge mclk);
        @(negedge mclk);
        clk_i = 1'b0;
        @(posedge mclk);
        @(negedge mclk);
        clk_i = 1'b1;
        repeat (14) @(posedge mclk);
        #1;
        chk("miss_set", {miss_w, miss_s, miss_1}, {3{exp_miss}});
        chk("miss_dout_w", dout_w, pack2(acc_w[0], acc_w[1]));
        chk("miss_dout_s", dout_s, pack2(acc_s[0], acc_s[1]));
        chk("miss_dout_1", dout_1, lo5(acc_1));
        @(negedge mclk);
        clk_i = 1'b0;
        repeat (10) @(posedge mclk);
        for (int i = 0; i < 2; i++) begin
            rw = 10'($urandom_range(0, 1023));
            rs = 10'($urandom_range(0, 1023));
            r1 = 5'($urandom_range(0, 31));
            run_sample(rw, rs, r1);
        end

        // Reset while busy, with CLK_I still high at release
        @(negedge mclk);
        clk_i = 1'b1;
        repeat (4) @(posedge mclk);
        #1;
        chk("busy_before_reset", {busy_w, busy_s, busy_1}, 3'b111);
        do_reset(20);
        for (int i = 0; i < 16; i++) begin
            @(posedge mclk);
            #1;
            chk("post_reset_quiet", {dout_w, dout_s, dout_1, busy_w, busy_s, busy_1, clko_w, clko_s, clko_1}, 0);
        end
        @(negedge mclk);
        clk_i = 1'b0;
        repeat (10) @(posedge mclk);
        rw = 10'($urandom_range(0, 1023));
        rs = 10'($urandom_range(0, 1023));
        r1 = 5'($urandom_range(0, 31));
        run_sample(rw, rs, r1);
        chk("first_after_reset_w", dout_w, rw);
        chk("first_after_reset_s", dout_s, rs);
        chk("first_after_reset_1", dout_1, r1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
